// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the round-robin D-register write arbiter.
// LOCK_BURST_MAX is only used when DFF_WRITE_ARBITER_LOCK_EN is defined.
package dff_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int LOCK_BURST_MAX = 4;
   localparam int MAX_REQ        = 16;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } pick_t;

   // First set bit of req searching circularly from last+1, over nreq lanes.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                     input logic [3:0] last,
                                     input int nreq);
      pick_t r;
      int    idx;
      r.found = 1'b0;
      r.idx   = '0;
      for (int k = 1; k <= MAX_REQ; k++) begin
         if (k <= nreq) begin
            idx = (int'(last) + k) % nreq;
            if (!r.found && req[4'(idx)]) begin
               r.found = 1'b1;
               r.idx   = 4'(idx);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational circular first-one search starting just after the last owner.
module rr_priority_picker
   import dff_arb_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
)(
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last,
   output logic [IDW-1:0]  idx,
   output logic            found
);

   logic [MAX_REQ-1:0] req_pad;
   pick_t              pick;

   assign req_pad = MAX_REQ'(req);
   assign pick    = rr_pick(req_pad, 4'(last), NREQ);
   assign idx     = IDW'(pick.idx);
   assign found   = pick.found;

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter owning a shared WIDTH-bit register; each write is a grant/load pair.
// Define DFF_WRITE_ARBITER_LOCK_EN to add the per-requester lock input (bounded re-grant).
module dff_write_arbiter
   import dff_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   localparam int IDW  = $clog2(NREQ)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      q,
   output logic [IDW-1:0]        q_owner,
   output logic                  q_valid,
   output logic                  busy
`ifdef DFF_WRITE_ARBITER_LOCK_EN
   ,
   input  logic [NREQ-1:0]       lock
`endif
);

   state_t           state_reg, state_next;
   logic [NREQ-1:0]  gnt_reg, ack_reg;
   logic [WIDTH-1:0] q_reg;
   logic [IDW-1:0]   q_owner_reg, last_reg, winner_reg;
   logic             q_valid_reg;

   logic [IDW-1:0]   pick_idx, grant_idx;
   logic             pick_found, grant_valid, lock_take, load;
   logic [NREQ-1:0]  grant_onehot, winner_onehot;
   logic [WIDTH-1:0] wdata_arr [NREQ];

   rr_priority_picker #(.NREQ(NREQ)) u_picker (
      .req   (req),
      .last  (last_reg),
      .idx   (pick_idx),
      .found (pick_found)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_lane
         assign wdata_arr[gi]     = wdata[gi*WIDTH +: WIDTH];
         assign grant_onehot[gi]  = (grant_idx == IDW'(gi));
         assign winner_onehot[gi] = (winner_reg == IDW'(gi));
      end
   endgenerate

`ifdef DFF_WRITE_ARBITER_LOCK_EN
   logic       lock_hold_reg;
   logic [1:0] burst_reg;

   // A locked owner that is still requesting bypasses rotation until the burst cap.
   assign lock_take = lock_hold_reg && req[last_reg];

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_hold_reg <= 1'b0;
         burst_reg     <= '0;
      end else if (state_reg == IDLE) begin
         lock_hold_reg <= 1'b0;
         if (grant_valid)
            burst_reg <= lock_take ? burst_reg + 2'd1 : 2'd0;
      end else begin
         lock_hold_reg <= load && lock[winner_reg] &&
                          (burst_reg != 2'(LOCK_BURST_MAX - 1));
      end
   end
`else
   assign lock_take = 1'b0;
`endif

   assign grant_idx   = lock_take ? last_reg : pick_idx;
   assign grant_valid = lock_take || pick_found;

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (grant_valid) state_next = GRANT;
         GRANT:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      load = 1'b0;
      if (state_reg == GRANT) begin
         busy = 1'b1;
         load = req[winner_reg];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_reg     <= '0;
         ack_reg     <= '0;
         q_reg       <= '0;
         q_owner_reg <= '0;
         q_valid_reg <= 1'b0;
         winner_reg  <= '0;
         last_reg    <= IDW'(NREQ - 1);
      end else if (state_reg == IDLE) begin
         ack_reg <= '0;
         gnt_reg <= grant_valid ? grant_onehot : '0;
         if (grant_valid) winner_reg <= grant_idx;
      end else begin
         gnt_reg <= '0;
         // A dropped request aborts: nothing is written and the pointer stays put.
         ack_reg <= load ? winner_onehot : '0;
         if (load) begin
            q_reg       <= wdata_arr[winner_reg];
            q_owner_reg <= winner_reg;
            q_valid_reg <= 1'b1;
            last_reg    <= winner_reg;
         end
      end
   end

   assign gnt     = gnt_reg;
   assign ack     = ack_reg;
   assign q       = q_reg;
   assign q_owner = q_owner_reg;
   assign q_valid = q_valid_reg;

endmodule

// File: doc/dff_write_arbiter.md
Name: dff_write_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit rising-edge D-register among NREQ requesters.
- Sequences each write as a two-phase grant/load transaction and reports which requester owns the stored value.
- Sits between multiple producers and the shared D-register bank; it is the only writer of that register.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 8, data width of the shared register
IDW, $clog2(NREQ), requester index width (derived, localparam)

Ports:
clk  input  1  main clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req  input  NREQ  per-requester write request; held high until ack
wdata  input  NREQ*WIDTH  packed write data; requester i at bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, registered
ack  output  NREQ  one-hot single-cycle write-complete pulse
q  output  WIDTH  shared register contents
q_owner  output  IDW  index of requester that last wrote q
q_valid  output  1  high once q has been written since reset
busy  output  1  high while in GRANT state

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; gnt=0, ack=0, q=0, q_owner=0, q_valid=0, busy=0; last pointer=NREQ-1, so requester 0 has highest priority first.
- States: IDLE, GRANT.
- IDLE:
  - ack=0.
  - If any req bit is high, the winner is the first requester with req high, searching circularly from last+1.
  - gnt<=onehot(winner), registered winner index, state->GRANT.
  - If no req is high, stay in IDLE with gnt=0.
- GRANT:
  - busy=1.
  - If req[winner] is still high: q<=wdata[winner], q_owner<=winner, q_valid<=1, ack[winner] pulses for exactly one cycle (registered, coincident with q update), last<=winner, gnt<=0, state->IDLE.
  - If req[winner] has dropped (abort): no write, no ack, last unchanged, gnt<=0, state->IDLE.
- Latency: req rising at edge N -> gnt visible after edge N+1 -> q and ack updated after edge N+2. Peak throughput is one write per 2 cycles.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,...,NREQ-1,0. No requester waits more than NREQ transactions.
- Only the winner's wdata is sampled, and only on the load edge. Changes to other requesters' req/wdata during GRANT are ignored.
- A requester must drop req in the cycle after ack, or it re-enters arbitration; round-robin still applies.
- Reset during GRANT: no write occurs, and all outputs take reset values on that edge.
- gnt and ack are never multi-hot. gnt is never high in IDLE after the deassert edge.

Optional Feature:
- Macro: DFF_WRITE_ARBITER_LOCK_EN.
- With the macro: extra input port lock (NREQ bits).
  - If lock[winner] is high on the load edge and req[winner] is still high in the following IDLE cycle, the same winner is re-granted regardless of rotation.
  - The lock is limited to 4 consecutive grants, tracked by a 2-bit burst counter reset on any non-locked grant. After the limit, normal rotation resumes.
- Without the macro: no lock port, pure round-robin.

Decomposition:
- Shared package dff_arb_pkg:
  - state enum (IDLE, GRANT)
  - LOCK_BURST_MAX=4 constant
  - function rr_pick(req, last) returning index plus found flag
- One natural sub-module: rr_priority_picker (combinational circular first-one search, parameterised by NREQ). The FSM and register live in the top module.

Test Plan:
- Reset then req=4'b0001, wdata[7:0]=8'hA5 -> gnt=0001 after 1 edge; q=8'hA5, q_owner=0, q_valid=1, ack=0001 for one cycle after 2 edges.
- req=4'b1111 held, data i=8'h10+i -> writes in order owners 0,1,2,3,0; q sequence 10,11,12,13,10; ack one-hot each time, spaced 2 cycles.
- last=1, then req=4'b0011 -> requester 0 is skipped in favour of none higher; winner=0 only after 2,3 are checked idle. Verify grant order 0 then 1 on repeated requests.
- Grant to requester 2, then drop req[2] during GRANT -> no ack, q unchanged, next IDLE re-arbitrates from unchanged pointer.
- Assert rst during GRANT with wdata=8'hFF -> q=0, q_valid=0, gnt=0, ack=0 on that edge; first post-reset winner is requester 0.
- With DFF_WRITE_ARBITER_LOCK_EN: lock[1]=1, req=4'b0011 held -> requester 1 granted 4 times consecutively, then requester 0.
